// File: rtl/core_inst_seq_if.sv
// ----------------------------------------------------------------------------
// core_inst_seq_if
// Bundles the signals between the host vector stream, the sequencer and core.
//   start       host -> seq   1-cycle request to run one attention tile
//   in_data     host -> seq   Q/K vector (pr*bw bits)
//   in_valid    host -> seq   in_data valid
//   in_ready    seq  -> host  sequencer can accept a vector this cycle
//   ofifo_valid core -> seq   core ofifo holds a complete row
//   inst        seq  -> core  19-bit instruction word
//   mem_in      seq  -> core  qmem/kmem write data
//   busy, done  seq  -> host  status
// master = sequencer side, slave = host/core side.
// ----------------------------------------------------------------------------
interface core_inst_seq_if #(
    parameter int bw = 8,
    parameter int pr = 16
);
    logic                 start;
    logic [pr*bw-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 ofifo_valid;
    logic [18:0]          inst;
    logic [pr*bw-1:0]     mem_in;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, in_data, in_valid, ofifo_valid,
        output in_ready, inst, mem_in, busy, done
    );

    modport slave (
        output start, in_data, in_valid, ofifo_valid,
        input  in_ready, inst, mem_in, busy, done
    );
endinterface

// File: rtl/core_inst_seq.sv
// ----------------------------------------------------------------------------
// core_inst_seq
// Instruction sequencer for one attention tile of core. Streams n_q Q vectors
// into qmem and col K vectors into kmem, loads kernels into the MAC array,
// executes, drains ofifo into pmem, then replays pmem through the SFP twice
// (accumulate pass, divide pass).
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    core_inst_seq_if.master (start, in_data, in_valid, in_ready,
//          ofifo_valid, inst, mem_in, busy, done)
//
// All outputs are registered. The instruction word produced while the FSM is
// in a given state appears on inst one cycle later; in_ready/busy/done are
// registered from the next state so they line up with the state itself.
// ----------------------------------------------------------------------------
module core_inst_seq #(
    parameter int bw  = 8,
    parameter int pr  = 16,
    parameter int col = 8,
    parameter int n_q = 16
) (
    input  logic             clk,
    input  logic             reset,
    core_inst_seq_if.master  bus
);

    // FSM encoding
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_QWR   = 4'd1;
    localparam logic [3:0] S_KWR   = 4'd2;
    localparam logic [3:0] S_KLOAD = 4'd3;
    localparam logic [3:0] S_BUB   = 4'd4;
    localparam logic [3:0] S_EXEC  = 4'd5;
    localparam logic [3:0] S_PWR   = 4'd6;
    localparam logic [3:0] S_ACC   = 4'd7;
    localparam logic [3:0] S_DIV   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    // inst bit positions
    localparam int I_DIV   = 18;
    localparam int I_ACC   = 17;
    localparam int I_ORD   = 16;
    localparam int I_EXE   = 7;
    localparam int I_LOAD  = 6;
    localparam int I_QRD   = 5;
    localparam int I_QWR   = 4;
    localparam int I_KRD   = 3;
    localparam int I_KWR   = 2;
    localparam int I_PRD   = 1;
    localparam int I_PWR   = 0;

    // Terminal counts: counters are 4 bits, so n_q=16 ends on 15 without wrap.
    localparam logic [3:0] NQ_LAST  = 4'(n_q - 1);
    localparam logic [3:0] COL_LAST = 4'(col - 1);

    logic [3:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;      // row counter for streams / reads
    logic [3:0]        wcnt_q, wcnt_d;    // pmem write row in PWR
    logic              pend_q, pend_d;    // a read issued last cycle needs its follow-up
    logic              last_q, last_d;    // every row of the current pass has been read
    logic [18:0]       inst_q, inst_d;
    logic [pr*bw-1:0]  mem_in_q, mem_in_d;
    logic              in_ready_q, busy_q, done_q;
    logic              xfer;

    // Transfer uses the registered ready that the host actually saw.
    assign xfer = bus.in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        pend_d   = 1'b0;
        last_d   = last_q;
        inst_d   = '0;
        mem_in_d = mem_in_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_QWR;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    last_d  = 1'b0;
                end
            end

            S_QWR: begin
                if (xfer) begin
                    inst_d[I_QWR]  = 1'b1;
                    inst_d[15:12]  = cnt_q;
                    mem_in_d       = bus.in_data;
                    if (cnt_q == NQ_LAST) begin
                        cnt_d   = '0;
                        state_d = S_KWR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_KWR: begin
                if (xfer) begin
                    inst_d[I_KWR]  = 1'b1;
                    inst_d[15:12]  = cnt_q;
                    mem_in_d       = bus.in_data;
                    if (cnt_q == COL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_KLOAD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_KLOAD: begin
                inst_d[I_LOAD] = 1'b1;
                inst_d[I_KRD]  = 1'b1;
                inst_d[15:12]  = cnt_q;
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BUB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // One idle instruction between load and execute so the MAC array
            // never sees both in adjacent words from the same state.
            S_BUB: state_d = S_EXEC;

            S_EXEC: begin
                inst_d[I_EXE] = 1'b1;
                inst_d[I_QRD] = 1'b1;
                inst_d[15:12] = cnt_q;
                if (cnt_q == NQ_LAST) begin
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_PWR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // ofifo read and the pmem write of the previous row may share a
            // cycle; the write always lags its read by exactly one cycle.
            S_PWR: begin
                if (bus.ofifo_valid && !last_q) begin
                    inst_d[I_ORD] = 1'b1;
                    pend_d        = 1'b1;
                    if (cnt_q == NQ_LAST) last_d = 1'b1;
                    else                  cnt_d  = cnt_q + 4'd1;
                end
                if (pend_q) begin
                    inst_d[I_PWR] = 1'b1;
                    inst_d[11:8]  = wcnt_q;
                    if (wcnt_q == NQ_LAST) begin
                        state_d = S_ACC;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end

            // pmem has one cycle of read latency: the SFP strobe follows each
            // read by a cycle, giving n_q+1 cycles per pass.
            S_ACC, S_DIV: begin
                if (!last_q) begin
                    inst_d[I_PRD] = 1'b1;
                    inst_d[11:8]  = cnt_q;
                    pend_d        = 1'b1;
                    if (cnt_q == NQ_LAST) last_d = 1'b1;
                    else                  cnt_d  = cnt_q + 4'd1;
                end
                if (pend_q) begin
                    if (state_q == S_ACC) inst_d[I_ACC] = 1'b1;
                    else                  inst_d[I_DIV] = 1'b1;
                    if (last_q) begin
                        state_d = (state_q == S_ACC) ? S_DIV : S_DONE;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            pend_q     <= 1'b0;
            last_q     <= 1'b0;
            inst_q     <= '0;
            mem_in_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            inst_q     <= inst_d;
            mem_in_q   <= mem_in_d;
            in_ready_q <= (state_d == S_QWR) || (state_d == S_KWR);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign bus.inst     = inst_q;
    assign bus.mem_in   = mem_in_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
module tb_core_inst_seq;
    localparam int BW = 8, PR = 16, COL = 8, NQ = 16, W = PR*BW, MAXC = 400;
    localparam int B_DIV = 18, B_ACC = 17, B_ORD = 16, B_EXE = 7, B_LOAD = 6, B_QRD = 5,
                   B_QWR = 4, B_KRD = 3, B_KWR = 2, B_PRD = 1, B_PWR = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    core_inst_seq_if #(.bw(BW), .pr(PR)) bus();
    core_inst_seq #(.bw(BW), .pr(PR), .col(COL), .n_q(NQ)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [18:0]  r_inst [MAXC];
    logic         r_done [MAXC], r_busy [MAXC], r_rdy [MAXC], r_ov [MAXC];
    logic [W-1:0] r_mem  [MAXC];
    int           acc_cyc[$];
    logic [W-1:0] acc_dat[$];
    int           done_cyc, ncyc;

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W/32; i++) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Drives one tile and records every cycle (C1 = first cycle after start edge).
    // p_in/p_ov: percent chance of valid; p_in<0 alternates 1,0,1,0.
    task automatic run_tile(input int p_in, input int p_ov, input int stall_row, input int extra_start);
        int stall_left = 0, rd_seen = 0;
        bit stalled = 0;
        acc_cyc.delete(); acc_dat.delete();
        done_cyc = -1; ncyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            r_inst[c] = '0; r_done[c] = 0; r_busy[c] = 0; r_rdy[c] = 0; r_ov[c] = 0; r_mem[c] = '0;
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int c = 1; c < MAXC; c++) begin
            if (c > 1) @(negedge clk);
            r_inst[c] = bus.inst; r_done[c] = bus.done; r_busy[c] = bus.busy;
            r_rdy[c] = bus.in_ready; r_mem[c] = bus.mem_in; ncyc = c;
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (bus.inst[B_ORD]) rd_seen++;
            if (stall_row >= 0 && !stalled && rd_seen == stall_row) begin
                stalled = 1; stall_left = 5;
            end
            bus.ofifo_valid = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < p_ov);
            if (stall_left > 0) stall_left--;
            r_ov[c] = bus.ofifo_valid;
            bus.in_valid = (p_in < 0) ? (c % 2 == 1) : ($urandom_range(99) < p_in);
            bus.in_data  = rnd_vec();
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(c); acc_dat.push_back(bus.in_data);
            end
            bus.start = (c == extra_start);
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        bus.start = 0; bus.in_valid = 0; bus.ofifo_valid = 0;
        n_tests++;
        if (done_cyc < 0) begin
            n_fail++; $display("FAIL tile_timeout: done never seen, want within %0d cycles", MAXC);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (bus.inst !== 19'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.mem_in !== '0) begin
            n_fail++;
            $display("FAIL reset_state: inst=%h busy=%b done=%b rdy=%b want all 0",
                     bus.inst, bus.busy, bus.done, bus.in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.inst !== 19'd0) begin
            n_fail++; $display("FAIL idle_no_start: busy=%b inst=%h want 0", bus.busy, bus.inst);
        end
    endtask

    // Tied-valid tile compared cycle by cycle against the schedule the rules imply.
    task automatic test_full_tile();
        logic [18:0] ex [MAXC];
        int t, bad_busy = 0, bad_rdy = 0;
        run_tile(100, 100, -1, -1);
        for (int c = 0; c < MAXC; c++) ex[c] = '0;
        t = 2;  // one register stage after the first accepted beat
        for (int i = 0; i < NQ;  i++) ex[t++] = 19'((1 << B_QWR) | (i << 12));
        for (int i = 0; i < COL; i++) ex[t++] = 19'((1 << B_KWR) | (i << 12));
        for (int i = 0; i < COL; i++) ex[t++] = 19'((1 << B_LOAD) | (1 << B_KRD) | (i << 12));
        t++;    // bubble
        for (int i = 0; i < NQ;  i++) ex[t++] = 19'((1 << B_EXE) | (1 << B_QRD) | (i << 12));
        for (int i = 0; i < NQ;  i++) begin
            ex[t+i]   |= 19'(1 << B_ORD);
            ex[t+i+1] |= 19'((1 << B_PWR) | (i << 8));
        end
        t += NQ + 1;
        for (int i = 0; i < NQ; i++) begin
            ex[t+i] |= 19'((1 << B_PRD) | (i << 8)); ex[t+i+1] |= 19'(1 << B_ACC);
        end
        t += NQ + 1;
        for (int i = 0; i < NQ; i++) begin
            ex[t+i] |= 19'((1 << B_PRD) | (i << 8)); ex[t+i+1] |= 19'(1 << B_DIV);
        end
        t += NQ + 1;
        for (int c = 1; c <= t; c++) begin
            n_tests++;
            if (r_inst[c] !== ex[c]) begin
                n_fail++; $display("FAIL full_trace c=%0d: got %h want %h", c, r_inst[c], ex[c]);
            end
        end
        n_tests++;
        if (done_cyc != 16+8+9+16+17+17+17+1) begin
            n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, 101);
        end
        for (int c = 1; c <= 102; c++) begin
            if (r_busy[c] !== (c <= 101)) bad_busy++;
            if (r_rdy[c]  !== (c <= NQ + COL)) bad_rdy++;
        end
        n_tests++;
        if (bad_busy != 0) begin n_fail++; $display("FAIL full_busy: got %0d bad cycles want 0", bad_busy); end
        n_tests++;
        if (bad_rdy != 0)  begin n_fail++; $display("FAIL full_in_ready: got %0d bad cycles want 0", bad_rdy); end
    endtask

    task automatic test_in_valid_toggle();
        int nwr = 0;
        logic [18:0] want;
        run_tile(-1, 100, -1, -1);
        n_tests++;
        if (acc_cyc.size() != NQ + COL) begin
            n_fail++; $display("FAIL toggle_beats: got %0d want %0d", acc_cyc.size(), NQ + COL);
        end
        for (int k = 0; k < acc_cyc.size() && k < NQ + COL; k++) begin
            want = (k < NQ) ? 19'((1 << B_QWR) | (k << 12)) : 19'((1 << B_KWR) | ((k - NQ) << 12));
            n_tests++;
            if (r_inst[acc_cyc[k]+1] !== want) begin
                n_fail++; $display("FAIL toggle_wr beat %0d: got %h want %h", k, r_inst[acc_cyc[k]+1], want);
            end
            n_tests++;
            if (r_mem[acc_cyc[k]+1] !== acc_dat[k]) begin
                n_fail++; $display("FAIL toggle_mem_in beat %0d: got %h want %h", k, r_mem[acc_cyc[k]+1], acc_dat[k]);
            end
        end
        for (int c = 1; c <= ncyc; c++) if (r_inst[c][B_QWR] || r_inst[c][B_KWR]) nwr++;
        n_tests++;
        if (nwr != NQ + COL) begin n_fail++; $display("FAIL toggle_wr_count: got %0d want %0d", nwr, NQ + COL); end
    endtask

    task automatic test_pwr_stall();
        int wr_order = 0, bad = 0, row3 = 0, rd_n = 0, rd2_c = -1, rd3_c = -1;
        run_tile(100, 100, 3, -1);
        for (int c = 2; c <= ncyc; c++) begin
            if (r_inst[c][B_ORD]) begin
                if (!r_ov[c-1]) bad++;
                if (rd_n == 2) rd2_c = c;
                if (rd_n == 3) rd3_c = c;
                rd_n++;
            end
            if (r_inst[c][B_PWR]) begin
                if (!r_inst[c-1][B_ORD] || r_inst[c][11:8] != 4'(wr_order)) bad++;
                if (r_inst[c][11:8] == 4'd3) row3++;
                wr_order++;
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_rd_wr_pairing: got %0d bad want 0", bad); end
        n_tests++;
        if (row3 != 1) begin n_fail++; $display("FAIL stall_row3_writes: got %0d want 1", row3); end
        n_tests++;
        if (rd3_c - rd2_c != 6) begin
            n_fail++; $display("FAIL stall_gap: got %0d want 6 cycles between row2/row3 reads", rd3_c - rd2_c);
        end
        n_tests++;
        if (wr_order != NQ) begin n_fail++; $display("FAIL stall_wr_count: got %0d want %0d", wr_order, NQ); end
        n_tests++;
        if (done_cyc != 106) begin n_fail++; $display("FAIL stall_done_cycle: got %0d want 106", done_cyc); end
    endtask

    task automatic test_reset_exec();
        int nexe = 0, guard = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1; bus.ofifo_valid = 1'b1;
        while (nexe < 4 && guard < 200) begin
            @(negedge clk); guard++;
            if (bus.inst[B_EXE]) nexe++;
        end
        n_tests++;
        if (nexe < 4) begin n_fail++; $display("FAIL rst_exec_reach: got %0d exec cycles want 4", nexe); end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.inst !== 19'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_exec_clear: inst=%h busy=%b done=%b want 0", bus.inst, bus.busy, bus.done);
        end
        @(negedge clk); reset = 1'b0; bus.in_valid = 1'b0; bus.ofifo_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_no_resume: busy=%b want 0", bus.busy); end
        run_tile(100, 100, -1, -1);
        n_tests++;
        if (r_inst[2] !== 19'(1 << B_QWR)) begin
            n_fail++; $display("FAIL rst_exec_first_wr: got %h want %h", r_inst[2], 19'(1 << B_QWR));
        end
        n_tests++;
        if (done_cyc != 101) begin n_fail++; $display("FAIL rst_exec_done: got %0d want 101", done_cyc); end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        run_tile(100, 100, -1, 20);
        for (int c = 1; c <= ncyc; c++) if (r_done[c]) ndone++;
        n_tests++;
        if (ndone != 1) begin n_fail++; $display("FAIL start_kwr_done_pulses: got %0d want 1", ndone); end
        n_tests++;
        if (done_cyc != 101) begin n_fail++; $display("FAIL start_kwr_done_cycle: got %0d want 101", done_cyc); end
        n_tests++;
        if (r_busy[done_cyc+1] !== 1'b0 || r_busy[done_cyc+2] !== 1'b0) begin
            n_fail++; $display("FAIL start_kwr_restart: busy=%b%b want 00", r_busy[done_cyc+1], r_busy[done_cyc+2]);
        end
    endtask

    task automatic test_random_invariants();
        for (int it = 0; it < 3; it++) begin
            int conflict = 0, seq_bad = 0, nld = 0, nex = 0, nrd = 0, nacc = 0, ndiv = 0, ndone = 0;
            run_tile(60 + 10*it, 50 + 15*it, -1, -1);
            for (int c = 1; c <= ncyc; c++) begin
                logic [18:0] v = r_inst[c];
                if ((v[B_QRD] && v[B_QWR]) || (v[B_KRD] && v[B_KWR]) ||
                    (v[B_PRD] && v[B_PWR]) || (v[B_EXE] && v[B_LOAD])) conflict++;
                if (v[B_LOAD]) begin if (v[15:12] != 4'(nld)) seq_bad++; nld++; end
                if (v[B_EXE])  begin if (v[15:12] != 4'(nex)) seq_bad++; nex++; end
                if (v[B_PRD])  begin
                    if (v[11:8] != 4'(nrd % NQ)) seq_bad++;
                    if (nrd < NQ && !r_inst[c+1][B_ACC]) seq_bad++;
                    if (nrd >= NQ && !r_inst[c+1][B_DIV]) seq_bad++;
                    nrd++;
                end
                if (v[B_ACC]) begin if (!r_inst[c-1][B_PRD]) seq_bad++; nacc++; end
                if (v[B_DIV]) begin if (!r_inst[c-1][B_PRD]) seq_bad++; ndiv++; end
                if (r_done[c]) ndone++;
            end
            n_tests++;
            if (conflict != 0) begin n_fail++; $display("FAIL inv_conflict it%0d: got %0d want 0", it, conflict); end
            n_tests++;
            if (seq_bad != 0) begin n_fail++; $display("FAIL inv_sequence it%0d: got %0d bad want 0", it, seq_bad); end
            n_tests++;
            if (nld != COL || nex != NQ || nacc != NQ || ndiv != NQ || ndone != 1) begin
                n_fail++;
                $display("FAIL inv_counts it%0d: ld=%0d ex=%0d acc=%0d div=%0d done=%0d want %0d/%0d/%0d/%0d/1",
                         it, nld, nex, nacc, ndiv, ndone, COL, NQ, NQ, NQ);
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.ofifo_valid = 0;
        test_reset();
        test_full_tile();
        test_in_valid_toggle();
        test_pwr_stall();
        test_reset_exec();
        test_start_ignored();
        test_random_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
